// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, stop
// Each bit is held for the latched Prescale clk cycles; Busy covers the whole frame.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [IW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  // Prescale 0 wraps to 63 here, giving a 64-cycle bit.
  logic [5:0]    cnt_last;
  logic          bit_end;
  logic [IW-1:0] nxt_idx;

  assign cnt_last = prescale_q - 6'd1;
  assign bit_end  = (cnt_q == cnt_last);
  assign nxt_idx  = bit_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    parity_d   = parity_q;
    prescale_d = prescale_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    if (state_q == S_IDLE) begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      cnt_d  = '0;
      if (Data_Valid) begin
        data_d     = P_DATA;
        par_en_d   = PAR_EN;
        parity_d   = (^P_DATA) ^ PAR_TYP;
        prescale_d = Prescale;
        bit_d      = '0;
        state_d    = S_START;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
      end
    end else begin
      cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bit_d   = '0;
            tx_d    = data_q[0];
          end
          S_DATA: begin
            if (bit_q == LAST_IDX) begin
              state_d = par_en_q ? S_PARITY : S_STOP;
              tx_d    = par_en_q ? parity_q : 1'b1;
            end else begin
              bit_d = nxt_idx;
              tx_d  = data_q[nxt_idx];
            end
          end
          S_PARITY: begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
          default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      parity_q   <= 1'b0;
      prescale_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      parity_q   <= parity_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the UART block. It is the transmit-side counterpart of the RX deserializer and uses the same frame format: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit. A parallel byte is accepted on a single-cycle valid strobe and then serialized onto TX_OUT, with each bit held for Prescale clk cycles. Busy indicates that a frame is in flight.

Parameters:
DATA_WIDTH, 8, data bits per frame; the design is verified only at 8.

Ports:
clk  input  1  system clock; the oversampled bit clock shared with RX.
rst  input  1  reset, asynchronous, active-high.
P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on accept.
Data_Valid  input  1  request to send P_DATA; accepted only when Busy=0.
PAR_EN  input  1  1 = insert a parity bit after the data bits; sampled on accept.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on accept.
Prescale  input  6  clk cycles per bit; sampled on accept.
TX_OUT  output  1  serial line; idle high; registered.
Busy  output  1  high from accept until the end of the stop bit; registered.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - TX_OUT=1, Busy=0, state=IDLE.
  - Bit counter, cycle counter, shift register and latched configuration all cleared.
  - No partial frame resumes after reset release.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - Accept condition: Data_Valid=1 at a rising clk edge. At that edge:
    - latch P_DATA, PAR_EN, PAR_TYP and Prescale;
    - compute parity = XOR(P_DATA) XOR PAR_TYP;
    - go to START, drive TX_OUT=0 and Busy=1.
  - Latency from the accepting edge to the start bit on the line is 0 cycles (registered output updates on that edge).
- Bit timing:
  - A cycle counter runs from 0 to Pb-1, where Pb is the latched Prescale.
  - The state or bit advances on the edge where the counter is at Pb-1. Every bit therefore lasts exactly Pb cycles.
  - Prescale=0 is treated as Pb=64, because the counter wraps modulo 64.
  - Supported operating values are 8, 16 and 32. Any value from 1 to 63 gives a period of Pb cycles.
- START: TX_OUT=0 for Pb cycles, then go to DATA with bit index 0.
- DATA:
  - TX_OUT = latched data[bit index], LSB first, for Pb cycles per bit.
  - After bit 7, go to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY: TX_OUT = latched parity bit for Pb cycles, then go to STOP.
- STOP:
  - TX_OUT=1 for Pb cycles.
  - On the final edge, go to IDLE and clear Busy.
- Frame length: 10*Pb cycles with PAR_EN=0, 11*Pb with PAR_EN=1.
- Back-to-back frames:
  - Busy is still 1 at the edge that ends STOP, so a Data_Valid sampled on that edge is ignored.
  - The earliest next accept is the following edge. This gives a 1-cycle minimum idle-high gap between frames.
- While Busy=1:
  - Data_Valid is ignored; it is not queued.
  - Changes to P_DATA, PAR_EN, PAR_TYP and Prescale have no effect on the current frame.
- Data_Valid held high continuously: one frame is sent per acceptance, with a 1-cycle gap between frames, re-sampling P_DATA each time.
- No combinational path from any input to TX_OUT or Busy.

Test Plan:
- Reset: assert rst mid-frame (e.g. during data bit 3) -> TX_OUT=1 and Busy=0 immediately, without waiting for a clk edge; after release the line stays idle until a new Data_Valid.
- No parity: P_DATA=0xA5, PAR_EN=0, Prescale=8 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; Busy high for 80 cycles.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=16 -> parity bit 0, frame lasts 176 cycles. Then P_DATA=0x01 -> parity bit 1.
- Odd parity: P_DATA=0x01, PAR_EN=1, PAR_TYP=1, Prescale=32 -> parity bit 0; stop bit 1 for 32 cycles; Busy falls after 352 cycles.
- Busy interlock: pulse Data_Valid with P_DATA=0x3C during the DATA state of a 0xA5 frame -> the 0xA5 frame is unchanged and no 0x3C frame is ever sent.
- Back-to-back: Data_Valid held high with P_DATA=0x55, then 0xAA -> two complete frames separated by exactly 1 idle-high cycle; second frame carries 0xAA.
